demux_1ton_loader: RTL

- Sequential 1-to-N word distributor; the write-side counterpart of the N-to-1 word mux.
- Accepts a stream of WORD_SIZE words over a valid/ready handshake and scatters them, in slot order 0..NUM_OUTPUTS-1, into a registered packed bus.
- Used to load a weight vector into the packed options bus that downstream mux-based select logic reads.
- Flags completion and holds the bus until the consumer acknowledges.

---
 rtl/demux_1ton_loader_pkg.sv | 15 +
 rtl/demux_1ton_loader.sv | 100 ++++++++++
 2 files changed

// File: rtl/demux_1ton_loader_pkg.sv
// Shared types for the 1-to-N word loader and its companion N-to-1 mux.
package demux_1ton_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } loader_state_t;

  // Select/index width shared with the N-to-1 mux; a single slot still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_1ton_loader.sv
// Sequential 1-to-N word distributor: scatters a handshaked word stream into a packed slot bus.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for start; words ignored
// FILL    | accepting words into slot load_idx, in slot order
// FULL    | all slots loaded, out_bus held until out_ack
module demux_1ton_loader
  import demux_1ton_loader_pkg::*;
#(
  parameter int NUM_OUTPUTS = 4,
  parameter int WORD_SIZE   = 16,
  localparam int IDX_W      = idx_w(NUM_OUTPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [WORD_SIZE-1:0]             in_word,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [NUM_OUTPUTS*WORD_SIZE-1:0] out_bus,
  output logic                             out_valid,
  input  logic                             out_ack,
  output logic [NUM_OUTPUTS-1:0]           slot_we,
  output logic [IDX_W-1:0]                 load_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUTS - 1);

  loader_state_t                    state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [NUM_OUTPUTS*WORD_SIZE-1:0] bus_q;
  logic [NUM_OUTPUTS-1:0]           we_q, we_d;
  logic                             xfer;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xfer    = 1'b0;
    we_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          idx_d   = '0;
        end
      end
      ST_FILL: begin
        // A restart wins over a same-cycle word, which is dropped.
        if (start) begin
          idx_d = '0;
        end else if (in_valid) begin
          xfer = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_FULL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (out_ack) begin
          state_d = start ? ST_FILL : ST_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      we_d[k] = xfer && (idx_q == IDX_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      bus_q   <= '0;
      we_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        if (we_d[k]) bus_q[k*WORD_SIZE +: WORD_SIZE] <= in_word;
      end
    end
  end

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = (state_q == ST_FULL);
  assign out_bus   = bus_q;
  assign slot_we   = we_q;
  assign load_idx  = idx_q;

endmodule
